// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing control for the three-stage fetch/execute/writeback pipeline:
// RAW forwarding selects, load-use stalls, taken-branch flushes and debug event counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned REG_BITS     = 5,
  parameter int unsigned ZERO_REG     = 31,
  parameter int unsigned STALL_CYCLES = 1,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                clk,
  input  logic                Reset,
  input  logic                ex_valid,
  input  logic [REG_BITS-1:0] ex_rs1,
  input  logic [REG_BITS-1:0] ex_rs2,
  input  logic                ex_use_rs1,
  input  logic                ex_use_rs2,
  input  logic                wb_valid,
  input  logic [REG_BITS-1:0] wb_rd,
  input  logic                wb_regwrite,
  input  logic                wb_is_load,
  input  logic                wb_br_taken,
  output logic                pc_hold,
  output logic                pc_load,
  output logic                ex_hold,
  output logic                ex_bubble,
  output logic                wb_bubble,
  output logic                fwd_a,
  output logic                fwd_b,
  output logic                busy,
  output logic [CNT_W-1:0]    stall_count,
  output logic [CNT_W-1:0]    flush_count
);

  localparam int unsigned MaxCyc  = (STALL_CYCLES > FLUSH_CYCLES) ? STALL_CYCLES : FLUSH_CYCLES;
  localparam int unsigned CntBits = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

  localparam logic [CntBits-1:0] StallInit = CntBits'(STALL_CYCLES - 1);
  localparam logic [CntBits-1:0] FlushInit = CntBits'(FLUSH_CYCLES - 1);

  localparam logic [1:0] StRun   = 2'd0;
  localparam logic [1:0] StStall = 2'd1;
  localparam logic [1:0] StFlush = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CntBits-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

  logic wb_w, hit_a, hit_b, ld_haz;

  assign wb_w   = wb_valid & wb_regwrite & (wb_rd != REG_BITS'(ZERO_REG));
  assign hit_a  = ex_valid & ex_use_rs1 & wb_w & (ex_rs1 == wb_rd);
  assign hit_b  = ex_valid & ex_use_rs2 & wb_w & (ex_rs2 == wb_rd);
  assign ld_haz = (hit_a | hit_b) & wb_is_load;

  assign busy        = (state_q != StRun);
  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    pc_hold     = 1'b0;
    pc_load     = 1'b0;
    ex_hold     = 1'b0;
    ex_bubble   = 1'b0;
    wb_bubble   = 1'b0;
    fwd_a       = 1'b0;
    fwd_b       = 1'b0;

    case (state_q)
      StRun: begin
        if (wb_br_taken) begin
          pc_load     = 1'b1;
          ex_bubble   = 1'b1;
          wb_bubble   = 1'b1;
          flush_cnt_d = (flush_cnt_q == '1) ? flush_cnt_q : flush_cnt_q + CNT_W'(1);
          cnt_d       = FlushInit;
          if (FLUSH_CYCLES > 1) state_d = StFlush;
        end else if (ld_haz) begin
          pc_hold     = 1'b1;
          ex_hold     = 1'b1;
          wb_bubble   = 1'b1;
          stall_cnt_d = (stall_cnt_q == '1) ? stall_cnt_q : stall_cnt_q + CNT_W'(1);
          cnt_d       = StallInit;
          if (STALL_CYCLES > 1) state_d = StStall;
        end else begin
          fwd_a = hit_a;
          fwd_b = hit_b;
        end
      end
      StStall: begin
        // The detecting RUN cycle is the first held cycle; cnt counts the rest.
        pc_hold   = 1'b1;
        ex_hold   = 1'b1;
        wb_bubble = 1'b1;
        if (cnt_q <= CntBits'(1)) begin
          state_d = StRun;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CntBits'(1);
        end
      end
      StFlush: begin
        ex_bubble = 1'b1;
        if (cnt_q <= CntBits'(1)) begin
          state_d = StRun;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CntBits'(1);
        end
      end
      default: begin
        state_d = StRun;
        cnt_d   = '0;
      end
    endcase

    if (!Reset) begin
      pc_hold   = 1'b0;
      pc_load   = 1'b0;
      ex_hold   = 1'b0;
      ex_bubble = 1'b0;
      wb_bubble = 1'b0;
      fwd_a     = 1'b0;
      fwd_b     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!Reset) begin
      state_q     <= StRun;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: a default instance and a long-stall/flush, 2-bit-counter
// instance share stimulus and are checked against a cycle-count reference model.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       Reset = 1'b0;
  logic       ex_valid = 1'b0, ex_use_rs1 = 1'b0, ex_use_rs2 = 1'b0;
  logic [4:0] ex_rs1 = '0, ex_rs2 = '0, wb_rd = '0;
  logic       wb_valid = 1'b0, wb_regwrite = 1'b0, wb_is_load = 1'b0, wb_br_taken = 1'b0;

  logic        d_ph, d_pl, d_eh, d_eb, d_wb, d_fa, d_fb, d_busy;
  logic [15:0] d_stall, d_flush;
  logic        a_ph, a_pl, a_eh, a_eb, a_wb, a_fa, a_fb, a_busy;
  logic [1:0]  a_stall, a_flush;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl u_dut (
    .clk(clk), .Reset(Reset), .ex_valid(ex_valid), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_use_rs1(ex_use_rs1), .ex_use_rs2(ex_use_rs2), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_regwrite(wb_regwrite), .wb_is_load(wb_is_load), .wb_br_taken(wb_br_taken),
    .pc_hold(d_ph), .pc_load(d_pl), .ex_hold(d_eh), .ex_bubble(d_eb), .wb_bubble(d_wb),
    .fwd_a(d_fa), .fwd_b(d_fb), .busy(d_busy), .stall_count(d_stall), .flush_count(d_flush)
  );

  pipeline_hazard_ctrl #(
    .STALL_CYCLES(2), .FLUSH_CYCLES(3), .CNT_W(2)
  ) u_alt (
    .clk(clk), .Reset(Reset), .ex_valid(ex_valid), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_use_rs1(ex_use_rs1), .ex_use_rs2(ex_use_rs2), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_regwrite(wb_regwrite), .wb_is_load(wb_is_load), .wb_br_taken(wb_br_taken),
    .pc_hold(a_ph), .pc_load(a_pl), .ex_hold(a_eh), .ex_bubble(a_eb), .wb_bubble(a_wb),
    .fwd_a(a_fa), .fwd_b(a_fb), .busy(a_busy), .stall_count(a_stall), .flush_count(a_flush)
  );

  // Control vector order: {pc_hold, pc_load, ex_hold, ex_bubble, wb_bubble, fwd_a, fwd_b, busy}
  logic [7:0] d_ctrl, a_ctrl;
  assign d_ctrl = {d_ph, d_pl, d_eh, d_eb, d_wb, d_fa, d_fb, d_busy};
  assign a_ctrl = {a_ph, a_pl, a_eh, a_eb, a_wb, a_fa, a_fb, a_busy};

  typedef struct packed {
    int hold_left;   // STALL cycles still to come after the detecting cycle
    int flush_left;  // FLUSH cycles still to come after the branch cycle
    int stalls;
    int flushes;
  } mdl_t;

  mdl_t m[2];
  mdl_t m_nx[2];
  int   s_cyc[2]  = '{1, 2};
  int   f_cyc[2]  = '{2, 3};
  int   sat_max[2] = '{65535, 3};

  int tests = 0;
  int fails = 0;

  function automatic logic [7:0] model_eval(input int k, output mdl_t nx);
    mdl_t       cur;
    logic [7:0] e;
    logic       wb_w, hit_a, hit_b;
    cur   = m[k];
    nx    = cur;
    e     = '0;
    e[0]  = (cur.hold_left > 0) || (cur.flush_left > 0);
    wb_w  = wb_valid && wb_regwrite && (wb_rd != 5'd31);
    hit_a = ex_valid && ex_use_rs1 && wb_w && (ex_rs1 == wb_rd);
    hit_b = ex_valid && ex_use_rs2 && wb_w && (ex_rs2 == wb_rd);
    if (!Reset) begin
      nx = '{0, 0, 0, 0};
    end else if (cur.hold_left > 0) begin
      e[7] = 1'b1; e[5] = 1'b1; e[3] = 1'b1;
      nx.hold_left = cur.hold_left - 1;
    end else if (cur.flush_left > 0) begin
      e[4] = 1'b1;
      nx.flush_left = cur.flush_left - 1;
    end else if (wb_br_taken) begin
      e[6] = 1'b1; e[4] = 1'b1; e[3] = 1'b1;
      nx.flushes    = (cur.flushes < sat_max[k]) ? cur.flushes + 1 : cur.flushes;
      nx.flush_left = f_cyc[k] - 1;
    end else if ((hit_a || hit_b) && wb_is_load) begin
      e[7] = 1'b1; e[5] = 1'b1; e[3] = 1'b1;
      nx.stalls    = (cur.stalls < sat_max[k]) ? cur.stalls + 1 : cur.stalls;
      nx.hold_left = s_cyc[k] - 1;
    end else begin
      e[2] = hit_a;
      e[1] = hit_b;
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One pipeline cycle: drive, check both instances against the model, then clock.
  task automatic step(input logic rst, input logic v, input logic [4:0] r1, input logic [4:0] r2,
                      input logic u1, input logic u2, input logic wv, input logic [4:0] rd,
                      input logic rw, input logic ld, input logic br, output logic [7:0] obs);
    logic [7:0] e;
    @(negedge clk);
    Reset = rst; ex_valid = v; ex_rs1 = r1; ex_rs2 = r2; ex_use_rs1 = u1; ex_use_rs2 = u2;
    wb_valid = wv; wb_rd = rd; wb_regwrite = rw; wb_is_load = ld; wb_br_taken = br;
    #1;
    obs = d_ctrl;
    e = model_eval(0, m_nx[0]);
    check("main_ctrl", 32'(d_ctrl), 32'(e));
    check("main_stall_cnt", 32'(d_stall), 32'(m[0].stalls));
    check("main_flush_cnt", 32'(d_flush), 32'(m[0].flushes));
    e = model_eval(1, m_nx[1]);
    check("alt_ctrl", 32'(a_ctrl), 32'(e));
    check("alt_stall_cnt", 32'(a_stall), 32'(m[1].stalls));
    check("alt_flush_cnt", 32'(a_flush), 32'(m[1].flushes));
    @(posedge clk);
    m[0] = m_nx[0];
    m[1] = m_nx[1];
  endtask

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 3))
      0:       return 5'd3;
      1:       return 5'd5;
      2:       return 5'd31;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  initial begin
    logic [7:0] o;
    m[0] = '{0, 0, 0, 0};
    m[1] = '{0, 0, 0, 0};
    repeat (2) @(posedge clk);

    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, o);
    check("idle_after_reset", 32'(o), 32'h00);

    // Non-load RAW on both operands.
    step(1, 1, 3, 3, 1, 1, 1, 3, 1, 0, 0, o);
    check("raw_both_fwd", 32'(o), 32'h06);

    // Load-use on rs2: one held cycle, then WB is a bubble so no forward.
    step(1, 1, 0, 5, 0, 1, 1, 5, 1, 1, 0, o);
    check("load_use_hold", 32'(o), 32'hA8);
    step(1, 1, 0, 5, 0, 1, 0, 5, 1, 0, 0, o);
    check("after_stall_no_fwd", 32'(o), 32'h00);
    #1 check("stall_count_one", 32'(d_stall), 32'd1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, o);

    // Taken branch wins over a simultaneous load-use hazard.
    step(1, 1, 0, 5, 0, 1, 1, 5, 1, 1, 1, o);
    check("branch_over_ldhaz", 32'(o), 32'h58);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, o);
    check("flush_cycle", 32'(o), 32'h11);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, o);
    check("flush_done", 32'(o), 32'h00);
    #1 check("flush_count_one", 32'(d_flush), 32'd1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, o);

    // Reset held low for two cycles while in FLUSH.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, o);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, o);
    check("reset_in_flush", 32'(o), 32'h01);
    step(0, 1, 3, 3, 1, 1, 1, 3, 1, 0, 0, o);
    check("reset_forces_zero", 32'(o), 32'h00);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, o);
    check("run_after_reset", 32'(o), 32'h00);
    check("stall_cnt_cleared", 32'(d_stall), 32'd0);
    check("flush_cnt_cleared", 32'(d_flush), 32'd0);

    // XZR destination never hits.
    step(1, 1, 31, 0, 1, 0, 1, 31, 1, 1, 0, o);
    check("xzr_no_hazard", 32'(o), 32'h00);

    // Five load-use events: the 2-bit counter stops at 3.
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 5, 0, 1, 0, 1, 5, 1, 1, 0, o);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, o);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, o);
    end
    #1 check("alt_stall_saturated", 32'(a_stall), 32'd3);
    check("main_stall_five", 32'(d_stall), 32'd5);

    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 39) != 0), 1'($urandom), pick_reg(), pick_reg(), 1'($urandom),
           1'($urandom), ($urandom_range(0, 3) != 0), pick_reg(), ($urandom_range(0, 3) != 0),
           1'($urandom), ($urandom_range(0, 7) == 0), o);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Sequencer for the three-stage fetch/execute/writeback CPU pipeline. Advances once per phase-0 strobe.
- Detects read-after-write hazards between the EX sources and the WB destination. Generates forwarding selects, load-use stalls and taken-branch flushes.
- Drives the PC hold/load and pipeline-register hold/bubble controls.
- Keeps saturating stall and flush event counters for bring-up debug.

Parameters:
- REG_BITS, 5, width of register specifiers.
- ZERO_REG, 31, register index that is never a hazard source (XZR).
- STALL_CYCLES, 1, cycles held per load-use hazard (≥1).
- FLUSH_CYCLES, 2, cycles of bubble insertion after a taken branch (≥1).
- CNT_W, 16, width of the event counters.

Ports:
- clk  in  1  pipeline advance strobe (phase-0 clock); all state updates on its rising edge.
- Reset  in  1  reset, synchronous, active-low.
- ex_valid  in  1  EX stage holds a real instruction.
- ex_rs1  in  REG_BITS  EX source register A.
- ex_rs2  in  REG_BITS  EX source register B.
- ex_use_rs1  in  1  EX instruction reads rs1.
- ex_use_rs2  in  1  EX instruction reads rs2.
- wb_valid  in  1  WB stage holds a real instruction.
- wb_rd  in  REG_BITS  WB destination register.
- wb_regwrite  in  1  WB instruction writes the register file.
- wb_is_load  in  1  WB instruction is an SRAM load.
- wb_br_taken  in  1  branch resolved taken in WB.
- pc_hold  out  1  PC must not update this cycle.
- pc_load  out  1  PC loads the branch target this cycle.
- ex_hold  out  1  EX register keeps its contents.
- ex_bubble  out  1  EX register loads a NOP.
- wb_bubble  out  1  WB register loads a NOP.
- fwd_a  out  1  ALU A operand takes the WB result instead of the RF read.
- fwd_b  out  1  ALU B operand takes the WB result instead of the RF read.
- busy  out  1  state ≠ RUN.
- stall_count  out  CNT_W  load-use stall events, saturating.
- flush_count  out  CNT_W  taken-branch events, saturating.

Behaviour:
- Hazard terms (combinational):
  - wb_w = wb_valid & wb_regwrite & (wb_rd ≠ ZERO_REG).
  - hitA = ex_valid & ex_use_rs1 & wb_w & (ex_rs1 == wb_rd); hitB likewise using rs2.
  - ld_haz = (hitA | hitB) & wb_is_load.
- States: RUN, STALL, FLUSH. Down-counter cnt is wide enough for max(STALL_CYCLES, FLUSH_CYCLES).
- RUN, priority order:
  1. wb_br_taken: pc_load=1, ex_bubble=1, wb_bubble=1, fwd_a=fwd_b=0; flush_count+1. Next state is FLUSH with cnt=FLUSH_CYCLES-1, or RUN if FLUSH_CYCLES==1.
  2. else ld_haz: pc_hold=1, ex_hold=1, wb_bubble=1, fwd=0; stall_count+1. Next state is STALL with cnt=STALL_CYCLES-1, or RUN if STALL_CYCLES==1.
  3. else: fwd_a=hitA, fwd_b=hitB; all other controls 0.
- STALL:
  - Outputs: pc_hold=ex_hold=wb_bubble=1, fwd=0.
  - cnt decrements; returns to RUN when cnt==0.
  - wb_br_taken is ignored, since WB holds a bubble.
- FLUSH:
  - Outputs: ex_bubble=1, others 0, fwd=0.
  - cnt decrements; returns to RUN when cnt==0.
  - wb_br_taken is ignored, since flushed slots cannot branch.
- Output timing: outputs are decoded combinationally from state plus inputs in the same cycle, and are valid before the next clk edge.
- Mutual exclusion: pc_hold and pc_load are never both 1. ex_hold and ex_bubble are never both 1.
- Event counters: increment once per event, not per held cycle. They saturate at all-ones with no wrap.
- Reset==0 at a clk edge, including mid-STALL or mid-FLUSH:
  - state=RUN, cnt=0, both counters=0.
  - All control outputs are forced 0 while Reset is low.
- rd==ZERO_REG never hits. Simultaneous hitA and hitB on a non-load asserts both fwd_a and fwd_b.

Test Plan:
- Reset low 2 cycles in FLUSH (cnt=1) -> next cycle state RUN, busy=0, counters 0, all outputs 0.
- Non-load RAW: wb_rd=3, wb_regwrite=1, ex_rs1=3, ex_rs2=3, both uses=1 -> fwd_a=fwd_b=1, no stall, stall_count unchanged.
- Load-use: wb_is_load=1, wb_rd=5, ex_rs2=5, use_rs2=1, STALL_CYCLES=1 -> one cycle pc_hold=ex_hold=wb_bubble=1, stall_count=1, then RUN with fwd_b=0 (WB now a bubble).
- Taken branch with ld_haz also true -> pc_load=1, ex/wb_bubble=1, pc_hold=0, stall_count unchanged, flush_count=1; next cycle FLUSH: ex_bubble=1, busy=1; then RUN.
- wb_rd=31 matching ex_rs1=31, wb_is_load=1 -> no stall, fwd_a=0.
- CNT_W=2: drive 5 separate load-use events -> stall_count saturates at 3.
